// File: rtl/err_inject_channel.sv
// err_inject_channel: one-cycle channel model that corrupts symbols (clean/periodic/LFSR/single-shot) and counts errors
module err_inject_channel #(
  parameter int          W        = 2,
  parameter int          PER_LOG2 = 4,
  parameter int          BURST    = 1,
  parameter int          WINDOW   = 256,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     mask_i,
  input  logic [7:0]       thresh_i,
  input  logic             shot_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [W-1:0]     sym_i,
  output logic             valid_o,
  output logic [W-1:0]     sym_o,
  output logic [W-1:0]     err_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] err_sym_ct_o,
  output logic [CNT_W-1:0] err_bit_ct_o,
  output logic             window_done_o
);
  localparam logic [15:0] SEED0 = (SEED == 16'h0) ? 16'h0001 : SEED;
  localparam int          PER   = 1 << PER_LOG2;
  localparam logic [31:0] CMAX  = 32'((64'd1 << CNT_W) - 64'd1);
  logic             valid_q, wd_q, wd_d, armed_q, armed_d, in_win, shoot;
  logic [W-1:0]     sym_q, err_q, f, f_per, f_rnd;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] sym_ct_q, sym_ct_d, esym_ct_q, esym_ct_d, ebit_ct_q, ebit_ct_d;
  logic [31:0]      p, bsum;
  assign p      = 32'(sym_ct_q);
  assign in_win = p < 32'(WINDOW);
  assign shoot  = armed_q | shot_i;
  assign f_per  = (in_win && (p & 32'(PER - 1)) >= 32'(PER - BURST)) ? mask_i : '0;
  // bit b compares the low byte of the LFSR rotated left by 2b
  for (genvar b = 0; b < W; b++) begin : g_rnd
    assign f_rnd[b] = in_win && (8'(({lfsr_q, lfsr_q} << (2 * b)) >> 16) < thresh_i);
  end
  assign f = clear_i ? '0 :
             mode_i == 2'd1 ? f_per :
             mode_i == 2'd2 ? f_rnd :
             (mode_i == 2'd3 && shoot) ? mask_i : '0;
  assign bsum = 32'(ebit_ct_q) + 32'($countones(f));
  always_comb begin
    sym_ct_d  = sym_ct_q;
    esym_ct_d = esym_ct_q;
    ebit_ct_d = ebit_ct_q;
    lfsr_d    = lfsr_q;
    armed_d   = armed_q;
    if (clear_i) begin
      sym_ct_d  = '0;
      esym_ct_d = '0;
      ebit_ct_d = '0;
      lfsr_d    = SEED0;
      armed_d   = 1'b0;
    end else if (valid_i) begin
      sym_ct_d  = &sym_ct_q ? sym_ct_q : sym_ct_q + CNT_W'(1);
      esym_ct_d = (|f && !(&esym_ct_q)) ? esym_ct_q + CNT_W'(1) : esym_ct_q;
      ebit_ct_d = bsum > CMAX ? CNT_W'(CMAX) : CNT_W'(bsum);
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      armed_d   = mode_i == 2'd3 ? 1'b0 : armed_q;
    end else begin
      armed_d   = armed_q | (mode_i == 2'd3 && shot_i);
    end
    wd_d = 32'(sym_ct_d) >= 32'(WINDOW);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      sym_q     <= '0;
      err_q     <= '0;
      sym_ct_q  <= '0;
      esym_ct_q <= '0;
      ebit_ct_q <= '0;
      wd_q      <= 1'b0;
      armed_q   <= 1'b0;
      lfsr_q    <= SEED0;
    end else begin
      valid_q   <= valid_i;
      err_q     <= valid_i ? f : '0;
      if (valid_i) sym_q <= sym_i ^ f;
      sym_ct_q  <= sym_ct_d;
      esym_ct_q <= esym_ct_d;
      ebit_ct_q <= ebit_ct_d;
      wd_q      <= wd_d;
      armed_q   <= armed_d;
      lfsr_q    <= lfsr_d;
    end
  end
  assign valid_o       = valid_q;
  assign sym_o         = sym_q;
  assign err_o         = err_q;
  assign sym_ct_o      = sym_ct_q;
  assign err_sym_ct_o  = esym_ct_q;
  assign err_bit_ct_o  = ebit_ct_q;
  assign window_done_o = wd_q;
endmodule
